// File: rtl/forward_unit_pkg.sv
// rtl/forward_unit_pkg.sv - shared select/state types and counter helper for forward_unit
package forward_unit_pkg;

    typedef enum logic [1:0] {
        FWD_SEL_NONE  = 2'd0,
        FWD_SEL_EXMEM = 2'd1,
        FWD_SEL_MEMWB = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } fsm_state_t;

    localparam int unsigned STAT_W = 32;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a, input logic [1:0] inc);
        logic [STAT_W:0] s;
        s = {1'b0, a} + {{(STAT_W-1){1'b0}}, inc};
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/forward_unit_if.sv
// rtl/forward_unit_if.sv - ID/EX hazard bus; FWD_STATS_EN adds the statistics counters
interface forward_unit_if #(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
);
    logic              hold;
    logic              flush;
    logic [REG_AW-1:0] id_rs_a;
    logic [REG_AW-1:0] id_rs_b;
    logic              id_use_a;
    logic              id_use_b;
    logic [REG_AW-1:0] id_rd;
    logic              id_we;
    logic              id_load;
    logic [DATA_W-1:0] exmem_data;
    logic [DATA_W-1:0] memwb_data;
    logic              stall;
    logic              ALU_A_FOWD_en;
    logic              ALU_B_FOWD_en;
    logic [DATA_W-1:0] data_FOWD_A;
    logic [DATA_W-1:0] data_FOWD_B;
`ifdef FWD_STATS_EN
    logic [31:0]       fwd_count;
    logic [31:0]       stall_count;
`endif

    modport master (
        output hold, flush, id_rs_a, id_rs_b, id_use_a, id_use_b, id_rd, id_we, id_load,
               exmem_data, memwb_data,
        input  stall, ALU_A_FOWD_en, ALU_B_FOWD_en, data_FOWD_A, data_FOWD_B
`ifdef FWD_STATS_EN
        , input fwd_count, stall_count
`endif
    );

    modport slave (
        input  hold, flush, id_rs_a, id_rs_b, id_use_a, id_use_b, id_rd, id_we, id_load,
               exmem_data, memwb_data,
        output stall, ALU_A_FOWD_en, ALU_B_FOWD_en, data_FOWD_A, data_FOWD_B
`ifdef FWD_STATS_EN
        , output fwd_count, stall_count
`endif
    );
endinterface

// File: rtl/forward_unit_fwd_compare.sv
// rtl/forward_unit_fwd_compare.sv - per-operand hazard match and raw forward select
module fwd_compare
    import forward_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_use,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_we,
    input  logic              i_ex_load,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_we,
    output logic              o_load_hit,
    output fwd_sel_t          o_sel
);
    logic w_valid;
    logic w_hit_ex;
    logic w_hit_mem;

    // r0 reads are constant zero and must never pick up a forwarded value
    assign w_valid    = i_use && (i_rs != '0);
    assign w_hit_ex   = w_valid && (i_rs == i_ex_rd) && i_ex_we;
    assign w_hit_mem  = w_valid && (i_rs == i_mem_rd) && i_mem_we;
    assign o_load_hit = w_hit_ex && i_ex_load;

    always_comb begin
        o_sel = FWD_SEL_NONE;
        if (w_hit_ex && !i_ex_load) begin
            o_sel = FWD_SEL_EXMEM;
        end else if (w_hit_mem) begin
            o_sel = FWD_SEL_MEMWB;
        end
    end
endmodule

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - EX operand forwarding and load-use stall; FWD_STATS_EN adds counters
module forward_unit
    import forward_unit_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    forward_unit_if.slave  bus
);
    logic [REG_AW-1:0] r_ex_rd;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_ex_we;
    logic              r_mem_we;
    logic              r_ex_load;
    fwd_sel_t          r_sel_a;
    fwd_sel_t          r_sel_b;
    fsm_state_t        r_state;
    fsm_state_t        w_state_nxt;

    logic              w_load_hit_a;
    logic              w_load_hit_b;
    fwd_sel_t          w_cmp_sel_a;
    fwd_sel_t          w_cmp_sel_b;
    fwd_sel_t          w_sel_a_nxt;
    fwd_sel_t          w_sel_b_nxt;
    logic              w_stall;
    logic              w_kill;

    fwd_compare #(.REG_AW(REG_AW)) u_cmp_a (
        .i_rs(bus.id_rs_a), .i_use(bus.id_use_a),
        .i_ex_rd(r_ex_rd), .i_ex_we(r_ex_we), .i_ex_load(r_ex_load),
        .i_mem_rd(r_mem_rd), .i_mem_we(r_mem_we),
        .o_load_hit(w_load_hit_a), .o_sel(w_cmp_sel_a)
    );

    fwd_compare #(.REG_AW(REG_AW)) u_cmp_b (
        .i_rs(bus.id_rs_b), .i_use(bus.id_use_b),
        .i_ex_rd(r_ex_rd), .i_ex_we(r_ex_we), .i_ex_load(r_ex_load),
        .i_mem_rd(r_mem_rd), .i_mem_we(r_mem_we),
        .o_load_hit(w_load_hit_b), .o_sel(w_cmp_sel_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // BUBBLE suppresses the stall so one load-use costs exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall = (w_load_hit_a || w_load_hit_b) && !bus.flush;
                if (w_stall && !bus.hold) begin
                    w_state_nxt = ST_BUBBLE;
                end
            end
            ST_BUBBLE: begin
                if (!bus.hold) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign w_kill      = w_stall || bus.flush;
    assign w_sel_a_nxt = w_kill ? FWD_SEL_NONE : w_cmp_sel_a;
    assign w_sel_b_nxt = w_kill ? FWD_SEL_NONE : w_cmp_sel_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_rd   <= '0;
            r_mem_rd  <= '0;
            r_ex_we   <= 1'b0;
            r_mem_we  <= 1'b0;
            r_ex_load <= 1'b0;
            r_sel_a   <= FWD_SEL_NONE;
            r_sel_b   <= FWD_SEL_NONE;
        end else if (!bus.hold) begin
            r_mem_rd  <= r_ex_rd;
            r_mem_we  <= r_ex_we;
            r_ex_rd   <= bus.id_rd;
            r_ex_we   <= bus.id_we && !w_kill;
            r_ex_load <= bus.id_load && !w_kill;
            r_sel_a   <= w_sel_a_nxt;
            r_sel_b   <= w_sel_b_nxt;
        end
    end

    function automatic logic [DATA_W-1:0] pick(input fwd_sel_t sel,
                                               input logic [DATA_W-1:0] exmem,
                                               input logic [DATA_W-1:0] memwb);
        case (sel)
            FWD_SEL_EXMEM: return exmem;
            FWD_SEL_MEMWB: return memwb;
            default:       return '0;
        endcase
    endfunction

    assign bus.stall         = w_stall;
    assign bus.ALU_A_FOWD_en = (r_sel_a != FWD_SEL_NONE);
    assign bus.ALU_B_FOWD_en = (r_sel_b != FWD_SEL_NONE);
    assign bus.data_FOWD_A   = pick(r_sel_a, bus.exmem_data, bus.memwb_data);
    assign bus.data_FOWD_B   = pick(r_sel_b, bus.exmem_data, bus.memwb_data);

`ifdef FWD_STATS_EN
    logic [31:0] r_fwd_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_count   <= '0;
            r_stall_count <= '0;
        end else if (!bus.hold) begin
            r_fwd_count   <= sat_add(r_fwd_count,
                                     {1'b0, w_sel_a_nxt != FWD_SEL_NONE} +
                                     {1'b0, w_sel_b_nxt != FWD_SEL_NONE});
            r_stall_count <= sat_add(r_stall_count, {1'b0, w_stall});
        end
    end

    assign bus.fwd_count   = r_fwd_count;
    assign bus.stall_count = r_stall_count;
`endif
endmodule
